// File: rtl/sram_burst_master.sv
// sram_burst_master: burst initiator for a single-port word SRAM.
// One command (base address, word count, direction) streams words between the
// wr/rd valid-ready channels and the SRAM, at most one SRAM access per cycle.
// Read data returns through a small FIFO. An issue is allowed only while the
// FIFO occupancy plus the words still in flight is below RD_FIFO_DEPTH, so the
// FIFO can never overflow.
// Build option: define SRAM_RD_LAT2_EN for an SRAM with a registered output
// stage (read latency 2). Leave it undefined for read latency 1.
module sram_burst_master #(
  parameter int DW            = 32,
  parameter int MW            = 4,
  parameter int AW            = 14,
  parameter int LW            = 16,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic [MW-1:0] wr_strb,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] rem_q, rem_d;

  logic          issue, issue_last;
  logic          wr_ok;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [PW-1:0] wr_idx_q, rd_idx_q;
  logic [DW-1:0] fifo_data [RD_FIFO_DEPTH];
  logic          fifo_last [RD_FIFO_DEPTH];
  logic [CW:0]   occ;
  logic          credit_ok;
  logic          push, push_last, pop;

  logic          vld_p0, last_p0;
`ifdef SRAM_RD_LAT2_EN
  logic          vld_p1, last_p1;
`endif

  function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] i);
    return (i == PW'(RD_FIFO_DEPTH - 1)) ? '0 : i + PW'(1);
  endfunction

  assign occ       = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign credit_ok = (occ < (CW+1)'(RD_FIFO_DEPTH));

  assign rd_valid  = (fifo_cnt_q != '0);
  assign rd_data   = fifo_data[rd_idx_q];
  assign rd_last   = fifo_last[rd_idx_q];
  assign pop       = rd_valid & rd_ready;

  // Next-state, pointer/count updates and SRAM request decode
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    cmd_ready  = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    wr_ok      = 1'b0;
    wr_ready   = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_wem   = '0;
    sram_addr  = '0;
    sram_din   = '0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_d = cmd_addr;
          rem_d = cmd_len;
          if (cmd_len == '0)   state_d = S_DONE;
          else if (cmd_write)  state_d = S_WRITE;
          else                 state_d = S_READ;
        end
      end
      S_WRITE: begin
        wr_ok    = (rem_q != '0);
        wr_ready = wr_ok;
        if (wr_valid && wr_ok) begin
          sram_cs   = 1'b1;
          sram_we   = 1'b1;
          sram_wem  = wr_strb;
          sram_din  = wr_data;
          sram_addr = ptr_q;
          ptr_d     = ptr_q + AW'(1);
          rem_d     = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = S_DONE;
        end
      end
      S_READ: begin
        if ((rem_q != '0) && credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == LW'(1));
          sram_cs    = 1'b1;
          sram_addr  = ptr_q;
          ptr_d      = ptr_q + AW'(1);
          rem_d      = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((fifo_cnt_q == '0) && (inflight_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, address pointer and remaining-word count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // ---- stage p0: read issued last cycle; p1 adds the SRAM output register ----
  // Track which cycles carry returning read data, and whether it is the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
`ifdef SRAM_RD_LAT2_EN
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
`endif
    end else begin
      vld_p0  <= issue;
      last_p0 <= issue_last;
`ifdef SRAM_RD_LAT2_EN
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
`endif
    end
  end

`ifdef SRAM_RD_LAT2_EN
  assign push      = vld_p1;
  assign push_last = last_p1;
`else
  assign push      = vld_p0;
  assign push_last = last_p0;
`endif

  // In-flight read counter: up on issue, down when the word lands in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---- FIFO capture: sram_dout enters the return buffer ----
  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_idx_q <= idx_inc(wr_idx_q);
      if (pop)  rd_idx_q <= idx_inc(rd_idx_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage; data only, validity is tracked by the counters above
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_idx_q] <= sram_dout;
      fifo_last[wr_idx_q] <= push_last;
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed testbench for sram_burst_master with a behavioural byte-masked SRAM.
module tb_sram_burst_master;

  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int AW    = 14;
  localparam int LW    = 16;
  localparam int DEPTH = 4;
`ifdef SRAM_RD_LAT2_EN
  localparam int RDLAT = 2;
`else
  localparam int RDLAT = 1;
`endif

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic          sram_cs, sram_we;
  logic [MW-1:0] sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  sram_burst_master #(.DW(DW), .MW(MW), .AW(AW), .LW(LW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked writes, registered read data
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] dout_q, dout_q2;
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    dout_q  = '0;
    dout_q2 = '0;
  end
  always @(posedge clk) begin
    if (sram_cs && sram_we) begin
      for (int b = 0; b < MW; b++)
        if (sram_wem[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    end
    if (sram_cs && !sram_we) dout_q <= mem[sram_addr];
    dout_q2 <= dout_q;
  end
`ifdef SRAM_RD_LAT2_EN
  assign sram_dout = dout_q2;
`else
  assign sram_dout = dout_q;
`endif

  // Observations gathered by the drivers, checked by the scenario tasks
  logic [AW-1:0] o_addr [$];
  logic [MW-1:0] o_wem  [$];
  logic [DW-1:0] o_din  [$];
  int            o_cs_cyc [$];
  logic [DW-1:0] o_rx   [$];
  logic          o_last [$];
  int            o_rx_cyc [$];
  int            o_done_cnt, o_done_cyc, o_max_out, o_rdy_busy, o_we_bad;
  logic          o_acc, o_busy_after, o_ready_after, o_rdv_after;
  bit            o_timeout;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    o_addr.delete(); o_wem.delete(); o_din.delete(); o_cs_cyc.delete();
    o_rx.delete(); o_last.delete(); o_rx_cyc.delete();
    o_done_cnt = 0; o_done_cyc = 0; o_max_out = 0; o_rdy_busy = 0; o_we_bad = 0;
    o_acc = 1'b0; o_busy_after = 1'bx; o_ready_after = 1'bx; o_rdv_after = 1'bx;
    o_timeout = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input logic [DW-1:0] base, input logic [MW-1:0] s);
    int beat;
    bit fin;
    clear_obs();
    beat = 0;
    fin  = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = n;
    #1 o_acc = cmd_ready;
    next();
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 150 && !(fin && cyc > o_done_cyc + 2); cyc++) begin
      wr_valid = (beat < int'(n));
      wr_data  = base + DW'(beat);
      wr_strb  = s;
      #1;
      if (busy && cmd_ready) o_rdy_busy++;
      if (sram_cs) begin
        o_addr.push_back(sram_addr); o_wem.push_back(sram_wem);
        o_din.push_back(sram_din);   o_cs_cyc.push_back(cyc);
        if (!sram_we) o_we_bad++;
      end
      if (wr_valid && wr_ready) beat++;
      if (done) begin
        o_done_cnt++;
        if (!fin) o_done_cyc = cyc;
        fin = 1'b1;
      end
      if (fin && cyc == o_done_cyc + 1) begin
        o_busy_after = busy; o_ready_after = cmd_ready; o_rdv_after = rd_valid;
      end
      next();
    end
    wr_valid = 1'b0;
    if (!fin) o_timeout = 1'b1;
  endtask

  task automatic drive_read(input logic [AW-1:0] a, input logic [LW-1:0] n, input bit toggle);
    int issued;
    bit fin;
    clear_obs();
    issued = 0;
    fin    = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = n;
    #1 o_acc = cmd_ready;
    next();
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 300 && !(fin && cyc > o_done_cyc + 2); cyc++) begin
      rd_ready = toggle ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      #1;
      if (busy && cmd_ready) o_rdy_busy++;
      if (sram_cs) begin
        o_addr.push_back(sram_addr); o_cs_cyc.push_back(cyc);
        issued++;
        if (sram_we) o_we_bad++;
      end
      if (issued - o_rx.size() > o_max_out) o_max_out = issued - o_rx.size();
      if (rd_valid && rd_ready) begin
        o_rx.push_back(rd_data); o_last.push_back(rd_last); o_rx_cyc.push_back(cyc);
      end
      if (done) begin
        o_done_cnt++;
        if (!fin) o_done_cyc = cyc;
        fin = 1'b1;
      end
      if (fin && cyc == o_done_cyc + 1) begin
        o_busy_after = busy; o_ready_after = cmd_ready; o_rdv_after = rd_valid;
      end
      next();
    end
    rd_ready = 1'b0;
    if (!fin) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    next();
    n_cmp++;
    if ({cmd_ready, busy, done, wr_ready, rd_valid, rd_last, sram_cs, sram_we} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready, busy, done, wr_ready, rd_valid, rd_last, sram_cs, sram_we});
    end
    n_cmp++;
    if ({sram_wem, sram_addr, sram_din} !== '0) begin
      n_bad++;
      $display("FAIL reset_sram_bus: wem=%h addr=%h din=%h want all 0", sram_wem, sram_addr, sram_din);
    end
    rst = 1'b0;
    next();
  endtask

  task automatic test_write_burst();
    logic [AW-1:0] ga; logic [MW-1:0] gw; logic [DW-1:0] gd;
    drive_write(14'h0010, 16'd4, 32'h0000_00A0, 4'hF);
    n_cmp++;
    if (o_acc !== 1'b1) begin n_bad++; $display("FAIL wr_accept: got %b want 1", o_acc); end
    n_cmp++;
    if (o_addr.size() != 4) begin n_bad++; $display("FAIL wr_cs_count: got %0d want 4", o_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      ga = (i < o_addr.size()) ? o_addr[i] : 'x;
      gw = (i < o_wem.size())  ? o_wem[i]  : 'x;
      gd = (i < o_din.size())  ? o_din[i]  : 'x;
      n_cmp++;
      if ({ga, gw, gd} !== {14'h0010 + 14'(i), 4'hF, 32'h0000_00A0 + 32'(i)}) begin
        n_bad++;
        $display("FAIL wr_beat%0d: addr=%h wem=%h din=%h want addr=%h wem=f din=%h",
                 i, ga, gw, gd, 14'h0010 + 14'(i), 32'h0000_00A0 + 32'(i));
      end
    end
    n_cmp++;
    if (o_cs_cyc.size() != 4 || o_cs_cyc[0] != 1 || o_cs_cyc[3] != 4) begin
      n_bad++; $display("FAIL wr_cs_consecutive: got %0d cs cycles, not cycles 1..4", o_cs_cyc.size());
    end
    n_cmp++;
    if (o_done_cnt != 1 || o_done_cyc != 5) begin
      n_bad++; $display("FAIL wr_done: got %0d pulses at cycle %0d want 1 at 5", o_done_cnt, o_done_cyc);
    end
    n_cmp++;
    if ({o_busy_after, o_ready_after} !== 2'b01) begin
      n_bad++; $display("FAIL wr_after: busy/cmd_ready got %b want 01", {o_busy_after, o_ready_after});
    end
    n_cmp++;
    if (o_we_bad != 0 || o_rdy_busy != 0 || o_timeout) begin
      n_bad++; $display("FAIL wr_misc: we_bad=%0d ready_while_busy=%0d timeout=%0b want 0 0 0",
                        o_we_bad, o_rdy_busy, o_timeout);
    end
  endtask

  task automatic test_read_back();
    logic [DW-1:0] gd; logic [3:0] lasts;
    drive_read(14'h0010, 16'd4, 1'b0);
    n_cmp++;
    if (o_rx.size() != 4) begin n_bad++; $display("FAIL rd_count: got %0d want 4", o_rx.size()); end
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      gd = (i < o_rx.size()) ? o_rx[i] : 'x;
      if (i < o_last.size()) lasts[i] = o_last[i];
      n_cmp++;
      if (gd !== 32'h0000_00A0 + 32'(i)) begin
        n_bad++; $display("FAIL rd_word%0d: got %h want %h", i, gd, 32'h0000_00A0 + 32'(i));
      end
    end
    n_cmp++;
    if (lasts !== 4'b1000) begin n_bad++; $display("FAIL rd_last: got %b want 1000", lasts); end
    n_cmp++;
    if (o_addr.size() != 4 || o_addr[0] !== 14'h0010 || o_addr[3] !== 14'h0013) begin
      n_bad++; $display("FAIL rd_issue_addr: %0d issues, not 0x10..0x13", o_addr.size());
    end
    n_cmp++;
    if (o_rx_cyc.size() != 4 || o_rx_cyc[3] - o_rx_cyc[0] != 3) begin
      n_bad++; $display("FAIL rd_consecutive: words not on 4 consecutive cycles");
    end
    n_cmp++;
    if (o_rx_cyc.size() == 0 || o_cs_cyc.size() == 0 || o_rx_cyc[0] - o_cs_cyc[0] != RDLAT + 1) begin
      n_bad++; $display("FAIL rd_latency: first rd_valid not %0d cycles after first cs", RDLAT + 1);
    end
    n_cmp++;
    if (o_done_cnt != 1 || o_rdv_after !== 1'b0 || o_ready_after !== 1'b1 || o_we_bad != 0 || o_rdy_busy != 0) begin
      n_bad++; $display("FAIL rd_done: pulses=%0d rd_valid_after=%b cmd_ready_after=%b we_bad=%0d rdy_busy=%0d",
                        o_done_cnt, o_rdv_after, o_ready_after, o_we_bad, o_rdy_busy);
    end
  endtask

  task automatic test_read_toggle();
    logic [DW-1:0] gd; int nlast;
    drive_write(14'h0200, 16'd16, 32'hC000_0000, 4'hF);
    n_cmp++;
    if (o_done_cnt != 1 || o_addr.size() != 16) begin
      n_bad++; $display("FAIL tg_fill: done=%0d cs=%0d want 1 16", o_done_cnt, o_addr.size());
    end
    drive_read(14'h0200, 16'd16, 1'b1);
    n_cmp++;
    if (o_rx.size() != 16) begin n_bad++; $display("FAIL tg_count: got %0d want 16", o_rx.size()); end
    nlast = 0;
    for (int i = 0; i < 16; i++) begin
      gd = (i < o_rx.size()) ? o_rx[i] : 'x;
      if (i < o_last.size() && o_last[i]) nlast++;
      n_cmp++;
      if (gd !== 32'hC000_0000 + 32'(i)) begin
        n_bad++; $display("FAIL tg_word%0d: got %h want %h", i, gd, 32'hC000_0000 + 32'(i));
      end
    end
    n_cmp++;
    if (nlast != 1 || o_last.size() != 16 || o_last[15] !== 1'b1) begin
      n_bad++; $display("FAIL tg_last: %0d last flags, not only on word 15", nlast);
    end
    n_cmp++;
    if (o_max_out != DEPTH) begin
      n_bad++; $display("FAIL tg_credit: max outstanding got %0d want %0d", o_max_out, DEPTH);
    end
    n_cmp++;
    if (o_cs_cyc.size() != 16 || o_cs_cyc[15] - o_cs_cyc[0] + 1 <= 16) begin
      n_bad++; $display("FAIL tg_stall: %0d issues with no cs stall seen", o_cs_cyc.size());
    end
    n_cmp++;
    if (o_done_cnt != 1 || o_timeout) begin
      n_bad++; $display("FAIL tg_done: pulses=%0d timeout=%0b want 1 0", o_done_cnt, o_timeout);
    end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp_a [4];
    logic [AW-1:0] ga; logic [MW-1:0] gw; logic [DW-1:0] gd;
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    drive_write(14'h3FFE, 16'd4, 32'h1122_3344, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      ga = (i < o_addr.size()) ? o_addr[i] : 'x;
      gw = (i < o_wem.size())  ? o_wem[i]  : 'x;
      n_cmp++;
      if ({ga, gw} !== {exp_a[i], 4'b0001}) begin
        n_bad++; $display("FAIL wrap_beat%0d: addr=%h wem=%b want addr=%h wem=0001", i, ga, gw, exp_a[i]);
      end
    end
    drive_read(14'h3FFE, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      gd = (i < o_rx.size()) ? o_rx[i] : 'x;
      n_cmp++;
      if (gd !== 32'h0000_0044 + 32'(i)) begin
        n_bad++; $display("FAIL wrap_rd%0d: got %h want %h", i, gd, 32'h0000_0044 + 32'(i));
      end
    end
  endtask

  task automatic test_zero_len();
    drive_read(14'h0055, 16'd0, 1'b0);
    n_cmp++;
    if (o_addr.size() != 0 || o_rx.size() != 0) begin
      n_bad++; $display("FAIL zero_access: cs=%0d rx=%0d want 0 0", o_addr.size(), o_rx.size());
    end
    n_cmp++;
    if (o_done_cnt != 1 || o_done_cyc != 1) begin
      n_bad++; $display("FAIL zero_done: %0d pulses at cycle %0d want 1 at 1", o_done_cnt, o_done_cyc);
    end
    n_cmp++;
    if (o_ready_after !== 1'b1 || o_busy_after !== 1'b0) begin
      n_bad++; $display("FAIL zero_after: cmd_ready=%b busy=%b want 1 0", o_ready_after, o_busy_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] gd;
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0010; cmd_len = 16'd8;
    next();
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (sram_cs !== 1'b1) begin n_bad++; $display("FAIL rm_issue1: sram_cs got %b want 1", sram_cs); end
    next();
    #1;
    n_cmp++;
    if (sram_cs !== 1'b1) begin n_bad++; $display("FAIL rm_issue2: sram_cs got %b want 1", sram_cs); end
    next();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_ready, busy, done, wr_ready, rd_valid, rd_last, sram_cs, sram_we} !== 8'b1000_0000
        || {sram_wem, sram_addr, sram_din} !== '0) begin
      n_bad++;
      $display("FAIL rm_async: ctrl=%b wem=%h addr=%h din=%h want 10000000 and zeros",
               {cmd_ready, busy, done, wr_ready, rd_valid, rd_last, sram_cs, sram_we},
               sram_wem, sram_addr, sram_din);
    end
    next();
    next();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rd_valid, cmd_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rm_release: rd_valid/cmd_ready got %b want 01", {rd_valid, cmd_ready});
    end
    drive_read(14'h0010, 16'd4, 1'b0);
    n_cmp++;
    if (o_rx.size() != 4) begin n_bad++; $display("FAIL rm_count: got %0d want 4", o_rx.size()); end
    for (int i = 0; i < 4; i++) begin
      gd = (i < o_rx.size()) ? o_rx[i] : 'x;
      n_cmp++;
      if (gd !== 32'h0000_00A0 + 32'(i)) begin
        n_bad++; $display("FAIL rm_word%0d: got %h want %h", i, gd, 32'h0000_00A0 + 32'(i));
      end
    end
    n_cmp++;
    if (o_rx_cyc.size() == 0 || o_cs_cyc.size() == 0 || o_rx_cyc[0] - o_cs_cyc[0] != RDLAT + 1) begin
      n_bad++; $display("FAIL rm_stale: first rd_valid not %0d cycles after first cs", RDLAT + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    test_reset();
    test_write_burst();
    test_read_back();
    test_read_toggle();
    test_addr_wrap();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
